transpose_accumulator: RTL and testbench

TRANSPOSE_ACCUMULATOR -- requirements
Module: transpose_accumulator

---
 rtl/transpose_accumulator.sv | 160 ++++++++++++++++
 tb/tb_transpose_accumulator.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/transpose_accumulator.sv
// Transpose accumulator: per-column saturating accumulators drained in order.
// Ports: partial_in/col_id/partial_valid in, flush, out_* stream, busy, drain_done, drop_err.
module transpose_accumulator #(
  parameter int DW        = 16,
  parameter int Dimension = 16,
  parameter int ACC_W     = 24,
  parameter int OUT_SHIFT = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [DW-1:0] partial_in,
  input  logic [3:0]           col_id,
  input  logic                 partial_valid,
  input  logic                 flush,
  output logic signed [DW-1:0] out_data,
  output logic [3:0]           out_col,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy,
  output logic                 drain_done,
  output logic                 drop_err
);

  typedef enum logic {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam logic signed [ACC_W-1:0] AMAX =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] AMIN =
    {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [DW-1:0] OMAX =
    {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] OMIN =
    {1'b1, {(DW-1){1'b0}}};
  localparam logic [3:0] LAST = 4'(Dimension-1);

  state_t state_q, state_d;
  logic [3:0] ptr_q, ptr_d;
  logic signed [ACC_W-1:0] acc_q [Dimension];
  logic signed [ACC_W-1:0] acc_d [Dimension];
  logic done_q, done_d;
  logic drop_q, drop_d;

  logic in_range;
  logic accept;
  logic beat;
  logic last;
  logic signed [ACC_W-1:0] sel;
  logic signed [ACC_W-1:0] shifted;
  logic signed [DW-1:0] sat_out;
  logic [ACC_W-DW:0] top;

  // One extra bit of headroom; overflow shows as
  // disagreement between the two top bits.
  function automatic logic signed [ACC_W-1:0] sat_add(
    input logic signed [ACC_W-1:0] a,
    input logic signed [DW-1:0]    p
  );
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {{(ACC_W+1-DW){p[DW-1]}}, p};
    if (s[ACC_W] != s[ACC_W-1])
      return s[ACC_W] ? AMIN : AMAX;
    return s[ACC_W-1:0];
  endfunction

  assign in_range = (32'(col_id) < 32'(Dimension));
  assign accept   = (state_q == ACCUM) && partial_valid
                    && in_range;
  assign beat     = (state_q == DRAIN) && out_ready;
  assign last     = (ptr_q == LAST);

  always_comb begin
    sel = '0;
    for (int i = 0; i < Dimension; i++) begin
      if (ptr_q == 4'(i)) sel = acc_q[i];
    end
  end

  assign shifted = sel >>> OUT_SHIFT;
  assign top     = shifted[ACC_W-1:DW-1];

  // Value fits in DW when all bits from the DW sign
  // bit upward agree.
  always_comb begin
    sat_out = shifted[DW-1:0];
    if (!((&top) || (~|top)))
      sat_out = shifted[ACC_W-1] ? OMIN : OMAX;
  end

  assign out_valid  = (state_q == DRAIN);
  assign busy       = (state_q == DRAIN);
  assign out_col    = (state_q == DRAIN) ? ptr_q : 4'd0;
  assign out_last   = (state_q == DRAIN) && last;
  assign out_data   = (state_q == DRAIN) ? sat_out : '0;
  assign drain_done = done_q;
  assign drop_err   = drop_q;

  always_comb begin
    acc_d = acc_q;
    for (int i = 0; i < Dimension; i++) begin
      if (accept && (col_id == 4'(i)))
        acc_d[i] = sat_add(acc_q[i], partial_in);
      if (beat && (ptr_q == 4'(i)))
        acc_d[i] = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    done_d  = 1'b0;
    drop_d  = drop_q
              | (partial_valid
                 & ((state_q == DRAIN) | ~in_range));
    unique case (state_q)
      ACCUM: begin
        if (flush) begin
          state_d = DRAIN;
          ptr_d   = 4'd0;
        end
      end
      DRAIN: begin
        if (beat) begin
          ptr_d = ptr_q + 4'd1;
          if (last) begin
            state_d = ACCUM;
            ptr_d   = 4'd0;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = ACCUM;
        ptr_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      ptr_q   <= 4'd0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
      for (int i = 0; i < Dimension; i++)
        acc_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
      for (int i = 0; i < Dimension; i++)
        acc_q[i] <= acc_d[i];
    end
  end

endmodule

// File: tb/tb_transpose_accumulator.sv
// Directed bench for transpose_accumulator.
// Three instances share stimulus; they differ only in OUT_SHIFT (0, 1, 9).
module tb_transpose_accumulator;

  logic clk = 1'b0;
  logic rst_n;
  logic signed [15:0] partial_in;
  logic [3:0] col_id;
  logic partial_valid;
  logic flush;
  logic out_ready;

  logic [15:0] od [3];
  logic [3:0]  oc [3];
  logic ov [3];
  logic ol [3];
  logic ob [3];
  logic odn [3];
  logic oe [3];

  int checks = 0;
  int errors = 0;
  longint ea [16];
  int shifts [3] = '{0, 1, 9};

  always #5 clk = ~clk;

  transpose_accumulator #(.OUT_SHIFT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .partial_in(partial_in), .col_id(col_id),
    .partial_valid(partial_valid), .flush(flush),
    .out_data(od[0]), .out_col(oc[0]),
    .out_valid(ov[0]), .out_ready(out_ready),
    .out_last(ol[0]), .busy(ob[0]),
    .drain_done(odn[0]), .drop_err(oe[0])
  );

  transpose_accumulator #(.OUT_SHIFT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .partial_in(partial_in), .col_id(col_id),
    .partial_valid(partial_valid), .flush(flush),
    .out_data(od[1]), .out_col(oc[1]),
    .out_valid(ov[1]), .out_ready(out_ready),
    .out_last(ol[1]), .busy(ob[1]),
    .drain_done(odn[1]), .drop_err(oe[1])
  );

  transpose_accumulator #(.OUT_SHIFT(9)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .partial_in(partial_in), .col_id(col_id),
    .partial_valid(partial_valid), .flush(flush),
    .out_data(od[2]), .out_col(oc[2]),
    .out_valid(ov[2]), .out_ready(out_ready),
    .out_last(ol[2]), .busy(ob[2]),
    .drain_done(odn[2]), .drop_err(oe[2])
  );

  task automatic check(input string tag,
                       input longint got,
                       input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  function automatic longint omodel(input longint a,
                                    input int s);
    longint v;
    v = a >>> s;
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic longint sd(input logic [15:0] x);
    return longint'($signed(x));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int c, input int v);
    partial_valid = 1'b1;
    col_id        = 4'(c);
    partial_in    = 16'(v);
    step();
    partial_valid = 1'b0;
  endtask

  task automatic clear_ea();
    for (int i = 0; i < 16; i++) ea[i] = 0;
  endtask

  task automatic drain(input bit do_flush,
                       input int stall_at,
                       input int inject_at);
    if (do_flush) begin
      flush = 1'b1;
      step();
      flush = 1'b0;
    end
    check("done_low_in_drain", odn[0], 0);
    for (int i = 0; i < 16; i++) begin
      if (i == stall_at) begin
        out_ready = 1'b0;
        repeat (5) begin
          step();
          check("stall_valid", ov[0], 1);
          check("stall_col", oc[0], i);
          check("stall_data", sd(od[0]),
                omodel(ea[i], 0));
        end
        out_ready = 1'b1;
      end
      if (i == inject_at) begin
        partial_valid = 1'b1;
        col_id        = 4'd4;
        partial_in    = 16'sd1000;
      end
      check("beat_valid", ov[0], 1);
      check("beat_busy", ob[0], 1);
      check("beat_col", oc[0], i);
      check("beat_last", ol[0], (i == 15) ? 1 : 0);
      for (int d = 0; d < 3; d++)
        check("beat_data", sd(od[d]),
              omodel(ea[i], shifts[d]));
      step();
      partial_valid = 1'b0;
    end
    check("done_pulse", odn[0], 1);
    check("idle_valid", ov[0], 0);
    check("idle_busy", ob[0], 0);
    check("idle_col", oc[0], 0);
    check("idle_data", sd(od[0]), 0);
  endtask

  initial begin
    rst_n         = 1'b0;
    partial_in    = '0;
    col_id        = '0;
    partial_valid = 1'b0;
    flush         = 1'b0;
    out_ready     = 1'b1;
    #12;
    check("rst_valid", ov[0], 0);
    check("rst_busy", ob[0], 0);
    check("rst_last", ol[0], 0);
    check("rst_col", oc[0], 0);
    check("rst_data", sd(od[0]), 0);
    check("rst_done", odn[0], 0);
    check("rst_drop", oe[0], 0);
    @(negedge clk);
    rst_n = 1'b1;

    // accumulate and drain
    send(3, 100);
    send(3, 200);
    send(3, -50);
    clear_ea();
    ea[3] = 250;
    drain(1'b1, -1, -1);
    check("t1_drop", oe[0], 0);

    // second flush right on the drain_done cycle
    clear_ea();
    drain(1'b1, -1, -1);

    // backpressure at ptr 2
    send(2, 5);
    send(3, 9);
    clear_ea();
    ea[2] = 5;
    ea[3] = 9;
    drain(1'b1, 2, -1);

    // partial with flush, then a drop mid-drain
    partial_valid = 1'b1;
    col_id        = 4'd5;
    partial_in    = 16'sd7;
    flush         = 1'b1;
    step();
    partial_valid = 1'b0;
    flush         = 1'b0;
    clear_ea();
    ea[5] = 7;
    drain(1'b0, -1, 2);
    check("t4_drop_set", oe[0], 1);
    step();
    check("t4_done_one", odn[0], 0);
    check("t4_drop_sticky", oe[0], 1);

    // reset in the middle of a drain
    send(8, 11);
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("t5_col8", oc[0], 8);
    check("t5_data8", sd(od[0]), 11);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_valid", ov[0], 0);
    check("t5_async_busy", ob[0], 0);
    check("t5_async_col", oc[0], 0);
    check("t5_async_data", sd(od[0]), 0);
    check("t5_async_last", ol[0], 0);
    check("t5_async_drop", oe[0], 0);
    #2;
    rst_n = 1'b1;
    send(0, 3);
    clear_ea();
    ea[0] = 3;
    drain(1'b1, -1, -1);

    // saturation
    step();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    partial_valid = 1'b1;
    col_id        = 4'd0;
    partial_in    = 16'sd32767;
    repeat (300) step();
    col_id     = 4'd2;
    partial_in = -16'sd32768;
    repeat (300) step();
    col_id = 4'd1;
    step();
    partial_valid = 1'b0;
    clear_ea();
    ea[0] = 8388607;
    ea[1] = -32768;
    ea[2] = -8388608;
    drain(1'b1, -1, -1);
    check("t6_drop", oe[0], 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
